gpio_debounce: RTL and testbench

//  Multi-channel noise filter for GPIO inputs. Each channel synchronises its raw pin and

---
 rtl/gpio_pkg.sv | 17 +
 rtl/gpio_debounce_chan.sv | 80 ++++++++
 rtl/gpio_debounce.sv | 53 +++++
 tb/tb_gpio_debounce.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO constants so the debounce filter and the board-sensing logic agree on timing.
package gpio_pkg;

    localparam int DEBOUNCE_STABLE = 10;
    localparam int SYNC_STAGES     = 2;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_e;

    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_debounce_chan.sv
// One debounce channel: input synchroniser, mismatch run counter, filtered level and edge strobes.
module gpio_debounce_chan
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES   = gpio_pkg::SYNC_STAGES,
    parameter int STABLE_CYCLES = gpio_pkg::DEBOUNCE_STABLE,
    parameter bit INIT_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sample_en,
    input  logic pin_in,
    output logic level_out,
    output logic rise,
    output logic fall,
    output logic flip_nxt
);

    localparam int              CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_done;
    edge_e                  w_edge;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_done = en && sample_en && (w_s != r_level) && (r_cnt == LAST);

    always_comb begin
        w_edge = EDGE_NONE;
        if (w_done) begin
            w_edge = w_s ? EDGE_RISE : EDGE_FALL;
        end
    end

    // The synchroniser keeps running even while filtering is disabled or between sample ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= INIT_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= (w_edge == EDGE_RISE);
            r_fall <= (w_edge == EDGE_FALL);
            if (!en) begin
                r_cnt <= '0;
            end else if (sample_en) begin
                if (w_s == r_level) begin
                    r_cnt <= '0;
                end else if (w_done) begin
                    r_cnt   <= '0;
                    r_level <= w_s;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign level_out = r_level;
    assign rise      = r_rise;
    assign fall      = r_fall;
    assign flip_nxt  = w_done;

endmodule

// File: rtl/gpio_debounce.sv
// Multi-channel GPIO debounce filter: independent per-pin channels plus a combined change flag.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int CHANNELS      = 8,
    parameter int SYNC_STAGES   = gpio_pkg::SYNC_STAGES,
    parameter int STABLE_CYCLES = gpio_pkg::DEBOUNCE_STABLE,
    parameter bit INIT_LEVEL    = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] pin_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    logic [CHANNELS-1:0] w_flip;
    logic                r_any;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        gpio_debounce_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .INIT_LEVEL   (INIT_LEVEL)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .sample_en(sample_en),
            .pin_in   (pin_in[g]),
            .level_out(level_out[g]),
            .rise     (rise[g]),
            .fall     (fall[g]),
            .flip_nxt (w_flip[g])
        );
    end

    // Built from the channels' next-cycle flip terms so the flag lands with the strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_flip;
        end
    end

    assign any_change = r_any;

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: three configurations driven in parallel and checked against a run-length model.
module tb_gpio_debounce;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       sample_en = 1'b1;
    logic [7:0] pin_in = 8'h00;

    logic [7:0] lvl0, rs0, fl0, lvl1, rs1, fl1, lvl2, rs2, fl2;
    logic       any0, any1, any2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per configuration: delayed pin history, filtered level, mismatch run length.
    logic [7:0] m_hist [3][4];
    logic [7:0] m_lvl  [3];
    logic [7:0] m_rise [3];
    logic [7:0] m_fall [3];
    logic       m_any  [3];
    int         m_run  [3][8];

    always #5 clk = ~clk;

    gpio_debounce #(.CHANNELS(8), .SYNC_STAGES(2), .STABLE_CYCLES(10), .INIT_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_en(sample_en), .pin_in(pin_in),
        .level_out(lvl0), .rise(rs0), .fall(fl0), .any_change(any0));

    gpio_debounce #(.CHANNELS(8), .SYNC_STAGES(2), .STABLE_CYCLES(3), .INIT_LEVEL(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_en(sample_en), .pin_in(pin_in),
        .level_out(lvl1), .rise(rs1), .fall(fl1), .any_change(any1));

    gpio_debounce #(.CHANNELS(8), .SYNC_STAGES(3), .STABLE_CYCLES(1), .INIT_LEVEL(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_en(sample_en), .pin_in(pin_in),
        .level_out(lvl2), .rise(rs2), .fall(fl2), .any_change(any2));

    function automatic int syn(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int stab(input int d);
        return (d == 0) ? 10 : ((d == 1) ? 3 : 1);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_lvl[d]  = 8'h00;
            m_rise[d] = 8'h00;
            m_fall[d] = 8'h00;
            m_any[d]  = 1'b0;
            for (int c = 0; c < 8; c++) m_run[d][c] = 0;
            for (int i = 0; i < 4; i++) m_hist[d][i] = 8'h00;
        end
    endtask

    // A level flips once a run of STABLE consecutive sampled disagreements accumulates.
    task automatic model_step();
        logic [7:0] s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 3; d++) begin
            s = m_hist[d][syn(d)-1];
            m_rise[d] = 8'h00;
            m_fall[d] = 8'h00;
            for (int c = 0; c < 8; c++) begin
                if (!en) begin
                    m_run[d][c] = 0;
                end else if (sample_en) begin
                    if (s[c] == m_lvl[d][c]) begin
                        m_run[d][c] = 0;
                    end else begin
                        m_run[d][c] = m_run[d][c] + 1;
                        if (m_run[d][c] == stab(d)) begin
                            m_run[d][c]  = 0;
                            m_lvl[d][c]  = s[c];
                            m_rise[d][c] = s[c];
                            m_fall[d][c] = ~s[c];
                        end
                    end
                end
            end
            m_any[d] = |(m_rise[d] | m_fall[d]);
            for (int i = 3; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
            m_hist[d][0] = pin_in;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] l, r, f;
        logic       a;
        for (int d = 0; d < 3; d++) begin
            case (d)
                0:       begin l = lvl0; r = rs0; f = fl0; a = any0; end
                1:       begin l = lvl1; r = rs1; f = fl1; a = any1; end
                default: begin l = lvl2; r = rs2; f = fl2; a = any2; end
            endcase
            chk($sformatf("d%0d level_out", d), l, m_lvl[d]);
            chk($sformatf("d%0d rise", d), r, m_rise[d]);
            chk($sformatf("d%0d fall", d), f, m_fall[d]);
            chk($sformatf("d%0d any_change", d), {7'd0, a}, {7'd0, m_any[d]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset();

        // Reset held while the pins toggle
        for (int i = 0; i < 6; i++) begin
            pin_in = 8'($urandom);
            tick();
            chk("rst level", lvl0 | lvl1 | lvl2, 8'h00);
            chk("rst strobes", rs0 | fl0 | rs2 | fl1, 8'h00);
        end
        pin_in = 8'h00;
        ticks(2);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("release quiet", {7'd0, any0 | any1 | any2}, 8'h00);
        end

        // Clean rising step on CH0
        pin_in[0] = 1'b1;
        ticks(11);
        chk("step pre level", lvl0 & 8'h01, 8'h00);
        tick();
        chk("step level", lvl0 & 8'h01, 8'h01);
        chk("step rise", rs0, 8'h01);
        chk("step any", {7'd0, any0}, 8'h01);
        tick();
        chk("step rise width", rs0, 8'h00);
        chk("step any width", {7'd0, any0}, 8'h00);

        // Glitch on CH1 restarts the count
        pin_in[1] = 1'b1;
        ticks(9);
        pin_in[1] = 1'b0;
        tick();
        pin_in[1] = 1'b1;
        ticks(11);
        chk("glitch no flip", lvl0 & 8'h02, 8'h00);
        tick();
        chk("glitch flip", lvl0 & 8'h02, 8'h02);
        chk("glitch rise", rs0, 8'h02);

        // Simultaneous falls on CH2 and CH5
        pin_in[2] = 1'b1;
        pin_in[5] = 1'b1;
        ticks(14);
        chk("multi high", lvl0, 8'h27);
        pin_in[2] = 1'b0;
        pin_in[5] = 1'b0;
        ticks(11);
        chk("multi pre fall", fl0, 8'h00);
        tick();
        chk("multi fall", fl0, 8'h24);
        chk("multi no rise", rs0, 8'h00);
        chk("multi any", {7'd0, any0}, 8'h01);
        tick();
        chk("multi any once", {7'd0, any0}, 8'h00);
        chk("multi level", lvl0, 8'h03);

        // Sparse sample ticks, STABLE_CYCLES=3 configuration
        pin_in[3] = 1'b1;
        sample_en = 1'b0;
        ticks(3);
        for (int k = 1; k <= 3; k++) begin
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            chk($sformatf("sparse level k%0d", k), lvl1 & 8'h08, (k == 3) ? 8'h08 : 8'h00);
            chk($sformatf("sparse rise k%0d", k), rs1, (k == 3) ? 8'h08 : 8'h00);
            ticks(3);
            chk($sformatf("sparse hold k%0d", k), lvl1 & 8'h08, (k == 3) ? 8'h08 : 8'h00);
        end
        sample_en = 1'b1;
        ticks(6);
        chk("sparse d0 held count", lvl0 & 8'h08, 8'h00);
        tick();
        chk("sparse d0 flip", lvl0 & 8'h08, 8'h08);

        // Disable mid-count on CH4
        pin_in[4] = 1'b1;
        ticks(7);
        en = 1'b0;
        ticks(20);
        chk("en0 no flip", lvl0 & 8'h10, 8'h00);
        en = 1'b1;
        ticks(9);
        chk("en1 restart", lvl0 & 8'h10, 8'h00);
        tick();
        chk("en1 flip", lvl0 & 8'h10, 8'h10);
        chk("en1 rise", rs0, 8'h10);

        // Asynchronous reset mid-count on CH6
        pin_in[6] = 1'b1;
        ticks(7);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async rst level0", lvl0, 8'h00);
        chk("async rst level1", lvl1 | lvl2, 8'h00);
        chk("async rst strobes", rs0 | fl0 | rs1 | fl1, 8'h00);
        chk("async rst any", {7'd0, any0 | any1 | any2}, 8'h00);
        tick();
        pin_in = 8'h00;
        ticks(2);
        rst_n = 1'b1;
        ticks(5);

        // Randomised bursts with random enables and occasional resets
        for (int seg = 0; seg < 60; seg++) begin
            int hold;
            pin_in = 8'($urandom);
            hold = $urandom_range(1, 16);
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end
            for (int i = 0; i < hold; i++) begin
                en        = ($urandom_range(0, 15) != 0);
                sample_en = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        en        = 1'b1;
        sample_en = 1'b1;
        ticks(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
